// File: rtl/bram_port_arbiter.sv
// Shares one single-port block RAM between two requesters (0: loader/debug, 1: core).
// Round-robin arbitration on ties, fixed-latency reads answered with a one-cycle pulse.
module bram_port_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              req0_valid,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,
    output logic [ADDR_W-1:0] bram_addr,
    output logic              bram_wea,
    output logic [DATA_W-1:0] bram_din,
    input  logic [DATA_W-1:0] bram_dout,
    output logic              dbg_state
);

    // Handshake: a request transfers on a rising edge where reqN_valid && reqN_ready.
    // Ready is combinational from both valids, asserted only in IDLE; rspN_valid has no back-pressure.

    localparam int CNT_W = 3;

    typedef enum logic {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              last_grant;
    logic              owner;
    logic [CNT_W-1:0]  cnt;

    logic              grant0;
    logic              grant1;
    logic              accept;
    logic              sel;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              rd_done;

    always_comb begin
        grant0     = req0_valid & (~req1_valid | last_grant);
        grant1     = req1_valid & (~req0_valid | ~last_grant);
        req0_ready = (state == IDLE) & grant0;
        req1_ready = (state == IDLE) & grant1;
        accept     = req0_ready | req1_ready;
        sel        = req1_ready;
        sel_we     = sel ? req1_we    : req0_we;
        sel_addr   = sel ? req1_addr  : req0_addr;
        sel_wdata  = sel ? req1_wdata : req0_wdata;
        // Data is sampled on the RD_LAT-th edge after the accept edge.
        rd_done    = (state == RD_WAIT) && (cnt == CNT_W'(RD_LAT - 1));

        state_nxt = state;
        case (state)
            IDLE:    if (accept && !sel_we) state_nxt = RD_WAIT;
            RD_WAIT: if (rd_done)           state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign dbg_state = (state == RD_WAIT);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last_grant <= 1'b1;
            owner      <= 1'b0;
            cnt        <= '0;
            bram_addr  <= '0;
            bram_wea   <= 1'b0;
            bram_din   <= '0;
            rsp0_valid <= 1'b0;
            rsp0_rdata <= '0;
            rsp1_valid <= 1'b0;
            rsp1_rdata <= '0;
        end else begin
            bram_wea   <= 1'b0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;

            if (accept) begin
                bram_addr  <= sel_addr;
                bram_din   <= sel_wdata;
                bram_wea   <= sel_we;
                last_grant <= sel;
                if (!sel_we) begin
                    cnt   <= '0;
                    owner <= sel;
                end
            end

            if (state == RD_WAIT) begin
                cnt <= cnt + CNT_W'(1);
                if (rd_done) begin
                    if (owner) begin
                        rsp1_valid <= 1'b1;
                        rsp1_rdata <= bram_dout;
                    end else begin
                        rsp0_valid <= 1'b1;
                        rsp0_rdata <= bram_dout;
                    end
                end
            end
        end
    end

endmodule
